// File: rtl/ifu_fetch_stage.sv
// Non-pipelined instruction fetch stage: one imem read per instruction, {pc, inst} handed to decode.
// Optional performance counters are built only when IFU_PERF_CNT_EN is defined.
module ifu_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  // Handshake rule for every channel below: a transfer happens on the rising
  // edge where valid and ready/allowin are both high; valid and payload hold
  // steady until then.
  output logic                    imem_req_valid,
  output logic [DATA_WIDTH-1:0]   imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data,
  output logic [2*DATA_WIDTH-1:0] ifu_to_idu_bus,
  output logic                    ifu_to_idu_valid,
  input  logic                    idu_allowin,
  input  logic                    exu_nextpc_valid,
  input  logic [DATA_WIDTH-1:0]   exu_nextpc,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_stall_cnt,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_SEND = 3'd3,
    S_WAIT = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;

  logic req_fire;
  logic resp_fire;
  logic send_fire;
  logic req_stall;
  logic resp_stall;

  // Low PC bits are forced to zero on redirect, so they are never consumed.
  logic unused_nextpc_low;
  assign unused_nextpc_low = ^exu_nextpc[1:0];

  assign req_fire   = (state_q == S_REQ)  && imem_req_ready;
  assign resp_fire  = (state_q == S_RESP) && imem_resp_valid;
  assign send_fire  = (state_q == S_SEND) && idu_allowin;
  assign req_stall  = (state_q == S_REQ)  && !imem_req_ready;
  assign resp_stall = (state_q == S_RESP) && !imem_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_fire) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_fire) begin
          inst_d  = imem_resp_data;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (send_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        // The only place the PC moves after reset.
        if (exu_nextpc_valid) begin
          pc_d    = {exu_nextpc[DATA_WIDTH-1:2], 2'b00};
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registers only, never from inputs.
  assign imem_req_valid   = (state_q == S_REQ);
  assign imem_req_addr    = pc_q;
  assign ifu_to_idu_valid = (state_q == S_SEND);
  assign ifu_to_idu_bus   = {pc_q, inst_q};
  assign dbg_state_o      = state_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (send_fire)              perf_fetch_d = perf_fetch_q + 32'd1;
    if (req_stall || resp_stall) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  logic unused_perf_events;
  assign unused_perf_events = send_fire ^ req_stall ^ resp_stall;
  assign perf_fetch_cnt     = 32'h0;
  assign perf_stall_cnt     = 32'h0;
`endif

  // Held-request and held-bus properties for the two outbound channels.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (imem_req_valid && !imem_req_ready) |=> (imem_req_valid && $stable(imem_req_addr)));
  a_bus_hold: assert property (@(posedge clk) disable iff (rst)
    (ifu_to_idu_valid && !idu_allowin) |=> (ifu_to_idu_valid && $stable(ifu_to_idu_bus)));

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Bench for ifu_fetch_stage: vector table of full fetch transactions plus hand sequences for corner cases.
module tb_ifu_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid;
  logic        idu_allowin;
  logic        exu_nextpc_valid;
  logic [31:0] exu_nextpc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [2:0]  dbg_state_o;

  ifu_fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .ifu_to_idu_bus(ifu_to_idu_bus),
    .ifu_to_idu_valid(ifu_to_idu_valid), .idu_allowin(idu_allowin),
    .exu_nextpc_valid(exu_nextpc_valid), .exu_nextpc(exu_nextpc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] last_bus;
  logic [31:0] fetch_exp;
  logic [31:0] stall_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters();
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, fetch_exp);
    chk("perf_stall_cnt", perf_stall_cnt, stall_exp);
`else
    chk("perf_fetch_cnt_tied", perf_fetch_cnt, 0);
    chk("perf_stall_cnt_tied", perf_stall_cnt, 0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Entered in REQ; leaves the DUT in WAIT after the decode handshake.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] inst,
                          input int req_wait, input int resp_wait,
                          input int send_wait, input bit noise);
    logic [63:0] exp_bus;
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, addr);
    for (int i = 0; i < req_wait; i++) begin
      imem_req_ready = 1'b0;
      if (noise) begin
        exu_nextpc_valid = 1'b1;
        exu_nextpc       = $urandom;
      end
      step();
      exu_nextpc_valid = 1'b0;
      stall_exp++;
      chk("req_hold_valid", imem_req_valid, 1);
      chk("req_hold_addr", imem_req_addr, addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("req_dropped", imem_req_valid, 0);
    for (int i = 0; i < resp_wait; i++) begin
      step();
      stall_exp++;
      chk("resp_no_send", ifu_to_idu_valid, 0);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = inst;
    exp_q.push_back({addr, inst});
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    chk("send_valid", ifu_to_idu_valid, 1);
    for (int i = 0; i < send_wait; i++) begin
      idu_allowin = 1'b0;
      if (noise) begin
        exu_nextpc_valid = 1'b1;
        exu_nextpc       = $urandom;
        imem_resp_valid  = 1'b1;
        imem_resp_data   = $urandom;
      end
      if (exp_q.size() != 0) chk("bus_held", ifu_to_idu_bus, exp_q[0]);
      step();
      exu_nextpc_valid = 1'b0;
      imem_resp_valid  = 1'b0;
      chk("send_held_valid", ifu_to_idu_valid, 1);
    end
    idu_allowin = 1'b1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got empty queue expected an entry");
    end else begin
      exp_bus = exp_q.pop_front();
      chk("bus", ifu_to_idu_bus, exp_bus);
      last_bus = exp_bus;
    end
    step();
    idu_allowin = 1'b0;
    fetch_exp++;
    chk("wait_no_send", ifu_to_idu_valid, 0);
    chk("wait_no_req", imem_req_valid, 0);
    chk_counters();
  endtask

  // Entered in WAIT; a stray response must not disturb inst_r, then the strobe redirects.
  task automatic redirect(input logic [31:0] nextpc, input logic [31:0] exp_addr);
    imem_resp_valid = 1'b1;
    imem_resp_data  = $urandom;
    step();
    imem_resp_valid = 1'b0;
    chk("wait_bus_kept", ifu_to_idu_bus, last_bus);
    chk("wait_still", imem_req_valid, 0);
    exu_nextpc_valid = 1'b1;
    exu_nextpc       = nextpc;
    step();
    exu_nextpc_valid = 1'b0;
    chk("redirect_req", imem_req_valid, 1);
    chk("redirect_addr", imem_req_addr, exp_addr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] inst;
    int          req_wait;
    int          resp_wait;
    int          send_wait;
    bit          noise;
    logic [31:0] nextpc;
    logic [31:0] exp_next_addr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] cur_addr;
    logic [31:0] r;

    vecs[0] = '{32'h0010_0093, 0, 0, 0, 1'b0, 32'h8000_0123, 32'h8000_0120};
    vecs[1] = '{32'h0020_0113, 0, 0, 5, 1'b0, 32'h8000_0200, 32'h8000_0200};
    vecs[2] = '{32'h0030_0193, 3, 4, 0, 1'b0, 32'h8000_0007, 32'h8000_0004};
    vecs[3] = '{32'hFFFF_FFFF, 1, 1, 2, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_0000, 2, 0, 1, 1'b0, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{32'hDEAD_BEEF, 0, 2, 3, 1'b1, 32'h1234_5678, 32'h1234_5678};
    r = $urandom;
    vecs[6] = '{$urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b1, r, {r[31:2], 2'b00}};

    rst              = 1'b1;
    imem_req_ready   = 1'b0;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = '0;
    idu_allowin      = 1'b0;
    exu_nextpc_valid = 1'b0;
    exu_nextpc       = '0;
    fetch_exp        = '0;
    stall_exp        = '0;
    last_bus         = '0;

    // Reset for two cycles; state must hold its reset values.
    step();
    step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_send_valid", ifu_to_idu_valid, 0);
    chk("rst_bus", ifu_to_idu_bus, {RESET_PC, 32'h0});
    chk_counters();
    rst = 1'b0;
    chk("idle_cycle", imem_req_valid, 0);
    step();
    cur_addr = RESET_PC;

    // Table: fetch with the given waits, deliver, then redirect.
    for (int v = 0; v < 7; v++) begin
      do_fetch(cur_addr, vecs[v].inst, vecs[v].req_wait, vecs[v].resp_wait,
               vecs[v].send_wait, vecs[v].noise);
      redirect(vecs[v].nextpc, vecs[v].exp_next_addr);
      cur_addr = vecs[v].exp_next_addr;
    end

    // Reset while in RESP, with the response arriving one cycle later.
    chk("mid_req_addr", imem_req_addr, cur_addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    fetch_exp       = '0;
    stall_exp       = '0;
    chk("mid_rst_req_valid", imem_req_valid, 0);
    chk("mid_rst_send_valid", ifu_to_idu_valid, 0);
    chk("mid_rst_bus", ifu_to_idu_bus, {RESET_PC, 32'h0});
    chk_counters();
    step();
    imem_resp_valid = 1'b0;
    chk("mid_rst_bus_discard", ifu_to_idu_bus, {RESET_PC, 32'h0});
    chk("mid_rst_send_idle", ifu_to_idu_valid, 0);
    do_fetch(RESET_PC, 32'h0040_0213, 0, 0, 0, 1'b0);
    redirect(32'h8000_0010, 32'h8000_0010);

`ifdef IFU_PERF_CNT_EN
    // Counter wrap on the next handshake.
    force dut.perf_fetch_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_fetch_q;
    fetch_exp = 32'hFFFF_FFFF;
`endif
    do_fetch(32'h8000_0010, 32'h0050_0293, 1, 0, 0, 1'b0);

    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
